multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore-style FSM controller for the multi-cycle RV32I core. It is the successor to the single-cycle controller.
- Sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one unified memory port.
- Over the single-cycle version it adds: a memory ready handshake, all six branch conditions, jalr, auipc, srai/sub via funct7, and an illegal-opcode trap.
- Sits between the instruction register and the multi-cycle datapath muxes and enables.

Parameters:
- USE_MEM_READY, 1: when 1, memory states stall until mem_ready=1. When 0, mem_ready is ignored and treated as 1.
- SUPPORT_JALR, 1: when 1, opcode 1100111 is executed. When 0, it is decoded as illegal.
- TRAP_ILLEGAL, 1: when 1, an illegal opcode enters the sticky ILLEGAL state. When 0, it returns to FETCH with no side effects.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- OPcode  in  7  instr[6:0] from the instruction register
- Funct3  in  3  instr[14:12]
- Funct7  in  7  instr[31:25]
- Zero  in  1  ALU result == 0
- LtS  in  1  signed rs1 < rs2, from the ALU compare
- LtU  in  1  unsigned rs1 < rs2
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  enables the instruction register and OldPC register
- ResultSrc  out  2  result mux: 00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  ALU A input: 00=PC, 01=OldPC, 10=rs1, 11=zero
- ALUSrcB  out  2  ALU B input: 00=rs2, 01=Imm, 10=constant 4
- ALUControl  out  4  add=0000, sub=1000, sll=0001, slt=0010, sltu=0011, xor=0100, srl=0101, sra=1101, or=0110, and=0111
- ImmSrc  out  3  immediate format: I=000, S=001, B=010, J=011, U=100
- RegWrite  out  1  register file write enable
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal  out  1  high while in the ILLEGAL state

Behaviour:
- State register is asynchronously reset to FETCH on reset=0.
- While reset=0, PCWrite, MemWrite, IRWrite, RegWrite, instr_done and illegal are forced to 0. All other outputs take their FETCH values.
- Outputs are combinational functions of state, plus OPcode/Funct3/Funct7/flags/mem_ready where noted below.
- Any output not listed for a state is 0.
- ImmSrc is decoded from OPcode in every state: lw/jalr/I-ALU=000, sw=001, B=010, jal=011, lui/auipc=100, otherwise 000.
- ALUOp (internal) maps to ALUControl:
  - 00: add.
  - 01: sub.
  - 10: {Funct7[5] & (R-type | Funct3==101), Funct3}, except that I-type with Funct3=000 is always add.
- FETCH: AdrSrc=0, A=00, B=10, add, ResultSrc=10, IRWrite=PCWrite=mem_ready. Goes to DECODE on mem_ready, otherwise stays in FETCH.
- DECODE: A=01, B=01, add. Computes the branch/jal target into ALUOut. Next state by OPcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - anything else -> ILLEGAL
- MEMADR: A=10, B=01, add. Goes to MEMREAD if OPcode[5]=0, otherwise MEMWRITE.
- MEMREAD: AdrSrc=1. Stays until mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. Goes to FETCH.
- MEMWRITE: AdrSrc=1. MemWrite is held at 1 until mem_ready. Goes to FETCH on mem_ready, with instr_done=1 in that cycle.
- EXECR: A=10, B=00, ALUOp=10. Goes to ALUWB.
- EXECI: A=10, B=01, ALUOp=10. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. Goes to FETCH.
- BRANCH: A=10, B=00, sub, ResultSrc=00, PCWrite=take, instr_done=1. Goes to FETCH.
  - take per Funct3: 000=Zero, 001=~Zero, 100=LtS, 101=~LtS, 110=LtU, 111=~LtU.
  - Funct3 010 or 011 -> ILLEGAL, with PCWrite=0 and instr_done=0.
- JAL: A=01, B=10, add, ResultSrc=00, PCWrite=1. Goes to ALUWB, which writes OldPC+4.
- JALR: A=10, B=01, add, ResultSrc=10, PCWrite=1. Goes to JLINK. The datapath clears the target LSB.
- JLINK: A=01, B=10, add. Goes to ALUWB.
- LUI: A=11, B=01, add. Goes to ALUWB.
- AUIPC: A=01, B=01, add. Goes to ALUWB.
- ILLEGAL: illegal=1, all enables 0. Sticky until reset.
  - With TRAP_ILLEGAL=0, the state that would enter ILLEGAL instead goes to FETCH.
- Cycle counts with mem_ready always 1:
  - lw = 5
  - sw = 4
  - R/I/lui/auipc = 4
  - branch = 3
  - jal = 4
  - jalr = 5
- Reset asserted mid-instruction aborts it immediately. The following access restarts in FETCH.
- mem_ready in non-memory states is ignored.

Test Plan:
- Reset low, then high with mem_ready=1 and add x3,x1,x2 (OPcode 0110011, F3 000, F7 0000000): states FETCH, DECODE, EXECR, ALUWB. ALUControl=0000 in EXECR, RegWrite=1 in ALUWB, instr_done on cycle 4.
- sub (F7 0100000) gives ALUControl=1000. srai (0010011, F3 101, F7 0100000) gives 1101. addi with F7[5]=1 gives 0000.
- lw with mem_ready low for 3 cycles in MEMREAD: AdrSrc=1 held, then MEMWB RegWrite=1, ResultSrc=01. Total 8 cycles.
- bge with LtS=1: PCWrite=0. With LtS=0: PCWrite=1. bltu with LtU=1: PCWrite=1. F3=010: illegal=1 and stays high.
- jalr: PCWrite=1 with ResultSrc=10 in JALR, then JLINK A=01/B=10, then ALUWB RegWrite=1. With SUPPORT_JALR=0, the same opcode leads to illegal=1.
- reset pulsed low during MEMWRITE with mem_ready=0: MemWrite drops to 0 asynchronously and the state returns to FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I controller: Moore FSM driving datapath muxes/enables, unified memory port.
// Latency: lw 5, sw 4, R/I/lui/auipc/jal 4, branch 3, jalr 5 cycles with memory always ready.
// Backpressure: FETCH/MEMREAD/MEMWRITE stall on mem_ready=0; other states ignore it.
module multicycle_controller #(
    parameter bit USE_MEM_READY = 1'b1,
    parameter bit SUPPORT_JALR  = 1'b1,
    parameter bit TRAP_ILLEGAL  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] OPcode,
    input  logic [2:0] Funct3,
    input  logic [6:0] Funct7,
    input  logic       Zero,
    input  logic       LtS,
    input  logic       LtU,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JLINK,
        S_LUI, S_AUIPC, S_ILLEGAL
    } state_t;

    // Where a bad instruction goes: sticky trap, or silently back to fetch.
    localparam state_t S_FAULT = TRAP_ILLEGAL ? S_ILLEGAL : S_FETCH;

    state_t     state_q, state_d;
    logic       mem_rdy;
    logic [1:0] alu_op;
    logic       pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw;
    logic       done_raw, illegal_raw;
    logic       take;
    logic       is_rtype;
    logic       unused_funct7;

    assign mem_rdy       = USE_MEM_READY ? mem_ready : 1'b1;
    assign is_rtype      = (OPcode == OP_R);
    assign unused_funct7 = ^{Funct7[6], Funct7[4:0]};

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Branch condition from Funct3 and the ALU compare flags.
    always_comb begin
        take = 1'b0;
        case (Funct3)
            3'b000:  take = Zero;
            3'b001:  take = ~Zero;
            3'b100:  take = LtS;
            3'b101:  take = ~LtS;
            3'b110:  take = LtU;
            3'b111:  take = ~LtU;
            default: take = 1'b0;
        endcase
    end

    // Immediate format depends only on the opcode, in every state.
    always_comb begin
        ImmSrc = 3'b000;
        case (OPcode)
            OP_STORE:         ImmSrc = 3'b001;
            OP_BRANCH:        ImmSrc = 3'b010;
            OP_JAL:           ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
            default:          ImmSrc = 3'b000;
        endcase
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        state_d       = state_q;
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        alu_op        = 2'b00;
        pc_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        done_raw      = 1'b0;
        illegal_raw   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                ir_write_raw = mem_rdy;
                pc_write_raw = mem_rdy;
                if (mem_rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (OPcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = SUPPORT_JALR ? S_JALR : S_FAULT;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = OPcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
                done_raw      = mem_rdy;
                if (mem_rdy) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b00;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                if (Funct3 == 3'b010 || Funct3 == 3'b011) begin
                    state_d = S_FAULT;
                end else begin
                    pc_write_raw = take;
                    done_raw     = 1'b1;
                    state_d      = S_FETCH;
                end
            end
            S_JAL: begin
                ALUSrcA      = 2'b01;
                ALUSrcB      = 2'b10;
                pc_write_raw = 1'b1;
                state_d      = S_ALUWB;
            end
            // Target goes straight to PC through ResultSrc=10; datapath clears bit 0.
            S_JALR: begin
                ALUSrcA      = 2'b10;
                ALUSrcB      = 2'b01;
                ResultSrc    = 2'b10;
                pc_write_raw = 1'b1;
                state_d      = S_JLINK;
            end
            S_JLINK: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                state_d = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                state_d = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                state_d = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal_raw = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // ALU operation decode; funct7[5] selects sub/sra, but never turns addi into sub.
    always_comb begin
        ALUControl = 4'b0000;
        case (alu_op)
            2'b01: ALUControl = 4'b1000;
            2'b10: begin
                if (!is_rtype && Funct3 == 3'b000)
                    ALUControl = 4'b0000;
                else
                    ALUControl = {Funct7[5] & (is_rtype | (Funct3 == 3'b101)), Funct3};
            end
            default: ALUControl = 4'b0000;
        endcase
    end

    // Enables are suppressed combinationally while reset is held low.
    always_comb begin
        PCWrite    = pc_write_raw  & reset;
        MemWrite   = mem_write_raw & reset;
        IRWrite    = ir_write_raw  & reset;
        RegWrite   = reg_write_raw & reset;
        instr_done = done_raw      & reset;
        illegal    = illegal_raw   & reset;
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-state output vectors checked against hand values.
// Second instance with jalr disabled shares all inputs.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] OPcode;
    logic [2:0] Funct3;
    logic [6:0] Funct7;
    logic       Zero, LtS, LtU, mem_ready;

    logic       pcw1, adr1, mw1, irw1, rw1, done1, ill1;
    logic [1:0] rs1, a1, b1;
    logic [3:0] alu1;
    logic [2:0] imm1;
    logic       pcw2, adr2, mw2, irw2, rw2, done2, ill2;
    logic [1:0] rs2, a2, b2;
    logic [3:0] alu2;
    logic [2:0] imm2;
    logic [19:0] o1, o2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .OPcode(OPcode), .Funct3(Funct3), .Funct7(Funct7),
        .Zero(Zero), .LtS(LtS), .LtU(LtU), .mem_ready(mem_ready),
        .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(mw1), .IRWrite(irw1), .ResultSrc(rs1),
        .ALUSrcA(a1), .ALUSrcB(b1), .ALUControl(alu1), .ImmSrc(imm1), .RegWrite(rw1),
        .instr_done(done1), .illegal(ill1)
    );

    multicycle_controller #(.SUPPORT_JALR(1'b0)) dut_nojalr (
        .clk(clk), .reset(reset), .OPcode(OPcode), .Funct3(Funct3), .Funct7(Funct7),
        .Zero(Zero), .LtS(LtS), .LtU(LtU), .mem_ready(mem_ready),
        .PCWrite(pcw2), .AdrSrc(adr2), .MemWrite(mw2), .IRWrite(irw2), .ResultSrc(rs2),
        .ALUSrcA(a2), .ALUSrcB(b2), .ALUControl(alu2), .ImmSrc(imm2), .RegWrite(rw2),
        .instr_done(done2), .illegal(ill2)
    );

    assign o1 = {pcw1, adr1, mw1, irw1, rs1, a1, b1, alu1, imm1, rw1, done1, ill1};
    assign o2 = {pcw2, adr2, mw2, irw2, rs2, a2, b2, alu2, imm2, rw2, done2, ill2};

    // Pack hand-written field values in the same order as o1/o2.
    function automatic logic [19:0] ov(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [3:0] alu, input logic [2:0] imm,
                                       input logic rw, input logic done, input logic ill);
        return {pcw, adr, mw, irw, rs, a, b, alu, imm, rw, done, ill};
    endfunction

    task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%05h expected=%05h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // From FETCH: load an instruction, check FETCH and DECODE, end in the third state.
    task automatic go_to_exec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [2:0] imm, input string tag);
        OPcode = op; Funct3 = f3; Funct7 = f7;
        #1;
        chk({tag, "_fetch"}, o1, ov(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 4'h0, imm, 0, 0, 0));
        tick();
        chk({tag, "_decode"}, o1, ov(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'h0, imm, 0, 0, 0));
        tick();
    endtask

    task automatic run_alu(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [1:0] bsel, input logic [3:0] alu, input string tag);
        go_to_exec(op, f3, f7, 3'b000, tag);
        chk({tag, "_exec"}, o1, ov(0, 0, 0, 0, 2'b00, 2'b10, bsel, alu, 3'b000, 0, 0, 0));
        tick();
        chk({tag, "_wb"}, o1, ov(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b000, 1, 1, 0));
        tick();
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        reset = 1'b0; OPcode = 7'b0110011; Funct3 = 3'b000; Funct7 = 7'b0000000;
        Zero = 1'b0; LtS = 1'b0; LtU = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_outs", o1, ov(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 4'h0, 3'b000, 0, 0, 0));
        reset = 1'b1;

        // ALU ops: R uses rs2 (B=00), I uses Imm (B=01)
        run_alu(7'b0110011, 3'b000, 7'b0000000, 2'b00, 4'b0000, "add");
        run_alu(7'b0110011, 3'b000, 7'b0100000, 2'b00, 4'b1000, "sub");
        run_alu(7'b0010011, 3'b101, 7'b0100000, 2'b01, 4'b1101, "srai");
        run_alu(7'b0010011, 3'b000, 7'b0100000, 2'b01, 4'b0000, "addi_f7");
        run_alu(7'b0010011, 3'b101, 7'b0000000, 2'b01, 4'b0101, "srli");
        run_alu(7'b0110011, 3'b100, 7'b0000000, 2'b00, 4'b0100, "xor");

        // FETCH stalls without mem_ready
        mem_ready = 1'b0;
        #1;
        chk("fetch_stall", o1, ov(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 4'h0, 3'b000, 0, 0, 0));
        tick();
        chk("fetch_stall2", o1, ov(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 4'h0, 3'b000, 0, 0, 0));
        mem_ready = 1'b1;

        // lw with three wait cycles in MEMREAD: 8 cycles total
        go_to_exec(7'b0000011, 3'b010, 7'b0000000, 3'b000, "lw");
        chk("lw_memadr", o1, ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'h0, 3'b000, 0, 0, 0));
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lw_memread_wait", o1, ov(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b000, 0, 0, 0));
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("lw_memread_rdy", o1, ov(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b000, 0, 0, 0));
        tick();
        chk("lw_memwb", o1, ov(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 4'h0, 3'b000, 1, 1, 0));
        tick();

        // sw stalled in MEMWRITE, then aborted by reset
        go_to_exec(7'b0100011, 3'b010, 7'b0000000, 3'b001, "sw_a");
        chk("sw_a_memadr", o1, ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'h0, 3'b001, 0, 0, 0));
        tick();
        mem_ready = 1'b0;
        #1;
        chk("sw_a_wait", o1, ov(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b001, 0, 0, 0));
        tick();
        chk("sw_a_wait2", o1, ov(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b001, 0, 0, 0));
        reset = 1'b0;
        #1;
        chk("sw_a_reset", o1, ov(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 4'h0, 3'b001, 0, 0, 0));
        reset = 1'b1;
        mem_ready = 1'b1;

        // sw with memory ready: 4 cycles
        go_to_exec(7'b0100011, 3'b010, 7'b0000000, 3'b001, "sw");
        chk("sw_memadr", o1, ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'h0, 3'b001, 0, 0, 0));
        tick();
        chk("sw_memwrite", o1, ov(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b001, 0, 1, 0));
        tick();

        // jal, lui, auipc
        go_to_exec(7'b1101111, 3'b000, 7'b0000000, 3'b011, "jal");
        chk("jal_jal", o1, ov(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 4'h0, 3'b011, 0, 0, 0));
        tick();
        chk("jal_wb", o1, ov(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b011, 1, 1, 0));
        tick();
        go_to_exec(7'b0110111, 3'b000, 7'b0000000, 3'b100, "lui");
        chk("lui_lui", o1, ov(0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 4'h0, 3'b100, 0, 0, 0));
        tick();
        chk("lui_wb", o1, ov(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b100, 1, 1, 0));
        tick();
        go_to_exec(7'b0010111, 3'b000, 7'b0000000, 3'b100, "auipc");
        chk("auipc_auipc", o1, ov(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'h0, 3'b100, 0, 0, 0));
        tick();
        chk("auipc_wb", o1, ov(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b100, 1, 1, 0));
        tick();

        // jalr: 5 cycles; the no-jalr instance traps instead
        go_to_exec(7'b1100111, 3'b000, 7'b0000000, 3'b000, "jalr");
        chk("jalr_jalr", o1, ov(1, 0, 0, 0, 2'b10, 2'b10, 2'b01, 4'h0, 3'b000, 0, 0, 0));
        chk("nojalr_illegal", o2, ov(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b000, 0, 0, 1));
        tick();
        chk("jalr_jlink", o1, ov(0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 4'h0, 3'b000, 0, 0, 0));
        chk("nojalr_sticky", o2, ov(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b000, 0, 0, 1));
        tick();
        chk("jalr_wb", o1, ov(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b000, 1, 1, 0));
        tick();
        pulse_reset();
        chk("nojalr_recovered", o2, ov(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 4'h0, 3'b000, 0, 0, 0));

        // branches: take decided in the BRANCH cycle from the flags
        go_to_exec(7'b1100011, 3'b101, 7'b0000000, 3'b010, "bge");
        LtS = 1'b1;
        #1;
        chk("bge_lts1", o1, ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'h8, 3'b010, 0, 1, 0));
        LtS = 1'b0;
        #1;
        chk("bge_lts0", o1, ov(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'h8, 3'b010, 0, 1, 0));
        tick();
        go_to_exec(7'b1100011, 3'b110, 7'b0000000, 3'b010, "bltu");
        LtU = 1'b1;
        #1;
        chk("bltu_ltu1", o1, ov(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'h8, 3'b010, 0, 1, 0));
        LtU = 1'b0;
        tick();
        go_to_exec(7'b1100011, 3'b001, 7'b0000000, 3'b010, "bne");
        Zero = 1'b1;
        #1;
        chk("bne_zero1", o1, ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'h8, 3'b010, 0, 1, 0));
        tick();
        go_to_exec(7'b1100011, 3'b000, 7'b0000000, 3'b010, "beq");
        chk("beq_zero1", o1, ov(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'h8, 3'b010, 0, 1, 0));
        Zero = 1'b0;
        tick();

        // unknown opcode traps
        go_to_exec(7'b0000000, 3'b000, 7'b0000000, 3'b000, "badop");
        chk("badop_illegal", o1, ov(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b000, 0, 0, 1));
        tick();
        chk("badop_sticky", o1, ov(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b000, 0, 0, 1));
        pulse_reset();

        // branch with reserved Funct3 traps, no PC write or done, and stays trapped
        Zero = 1'b1;
        go_to_exec(7'b1100011, 3'b010, 7'b0000000, 3'b010, "bf3");
        chk("bf3_branch", o1, ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'h8, 3'b010, 0, 0, 0));
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("bf3_illegal", o1, ov(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b010, 0, 0, 1));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
